// File: rtl/mmio_store_ctrl_pkg.sv
// IO address map and store-side decode shared by the IO write controller and read mux.
package mmio_store_ctrl_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = 4;

  // Upper two address bits that select the IO region
  localparam logic [1:0] IO_REGION = 2'b10;

  // Register byte offsets within the IO region
  localparam logic [4:0] IO_UART_CTRL = 5'h00;
  localparam logic [4:0] IO_UART_RX   = 5'h04;
  localparam logic [4:0] IO_UART_TX   = 5'h08;
  localparam logic [4:0] IO_CYC_CNT   = 5'h10;
  localparam logic [4:0] IO_INSTR_CNT = 5'h14;
  localparam logic [4:0] IO_CNT_RST   = 5'h18;

  typedef enum logic [2:0] {
    IO_SEL_NONE,
    IO_SEL_UART_CTRL,
    IO_SEL_UART_RX,
    IO_SEL_UART_TX,
    IO_SEL_CYC_CNT,
    IO_SEL_INSTR_CNT,
    IO_SEL_CNT_RST
  } io_sel_e;

  // Map region bits and word offset (addr[4:2]) to a register select
  function automatic io_sel_e io_decode(input logic [1:0] region, input logic [2:0] word);
    io_sel_e sel;
    sel = IO_SEL_NONE;
    if (region == IO_REGION) begin
      case (word)
        IO_UART_CTRL[4:2]: sel = IO_SEL_UART_CTRL;
        IO_UART_RX[4:2]:   sel = IO_SEL_UART_RX;
        IO_UART_TX[4:2]:   sel = IO_SEL_UART_TX;
        IO_CYC_CNT[4:2]:   sel = IO_SEL_CYC_CNT;
        IO_INSTR_CNT[4:2]: sel = IO_SEL_INSTR_CNT;
        IO_CNT_RST[4:2]:   sel = IO_SEL_CNT_RST;
        default:           sel = IO_SEL_NONE;
      endcase
    end
    return sel;
  endfunction

endpackage

// File: rtl/mmio_store_ctrl_tx_fifo.sv
// Synchronous FIFO for UART TX bytes; head entry is presented straight from storage flops.
module io_tx_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic [WIDTH-1:0]         head_data
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push_c;
  logic             do_pop_c;

  // Accept a push when not full, or when full but a pop frees a slot this cycle
  always_comb begin
    do_pop_c  = pop & (count_q != '0);
    do_push_c = push & ((count_q != CNT_W'(DEPTH)) | do_pop_c);

    mem_d   = mem_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;

    if (do_push_c) begin
      mem_d[wptr_q] = push_data;
      wptr_d        = wptr_q + PTR_W'(1);
    end
    if (do_pop_c) begin
      rptr_d = rptr_q + PTR_W'(1);
    end
    case ({do_push_c, do_pop_c})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy state; reset flushes buffered entries
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Data storage needs no reset; occupancy gates its visibility
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign full      = (count_q == CNT_W'(DEPTH));
  assign empty     = (count_q == '0);
  assign count     = count_q;
  assign head_data = mem_q[rptr_q];

endmodule

// File: rtl/mmio_store_ctrl.sv
// Store-side MMIO controller: decodes IO stores, buffers UART TX bytes, owns perf counters.
module mmio_store_ctrl
  import mmio_store_ctrl_pkg::*;
#(
  parameter int unsigned TX_FIFO_DEPTH = 4,
  parameter int unsigned CNT_WIDTH     = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 st_we,
  input  logic [ADDR_W-1:0]    st_addr,
  input  logic [DATA_W-1:0]    st_data,
  input  logic [BE_W-1:0]      st_be,
  input  logic                 instr_retire,
  output logic [7:0]           uart_tx_data,
  output logic                 uart_tx_valid,
  input  logic                 uart_tx_ready,
  output logic                 tx_ready_status,
  output logic                 tx_overflow,
  output logic [CNT_WIDTH-1:0] cyc_counter,
  output logic [CNT_WIDTH-1:0] instr_counter
);

  localparam int unsigned FIFO_CNT_W = $clog2(TX_FIFO_DEPTH) + 1;

  io_sel_e                 io_sel_c;
  logic                    tx_push_c;
  logic                    tx_pop_c;
  logic                    cnt_rst_c;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic [FIFO_CNT_W-1:0]   fifo_count;
  logic [7:0]              fifo_head;

  logic                    overflow_q, overflow_d;
  logic [CNT_WIDTH-1:0]    cyc_q, cyc_d;
  logic [CNT_WIDTH-1:0]    instr_q, instr_d;

  // Address bits and data lanes this block never looks at
  logic unused_store_bits;
  assign unused_store_bits = ^{st_addr[29:5], st_addr[1:0], st_data[31:8]};

  // Decode a valid stage-3 store into a register select and its side effects
  always_comb begin
    io_sel_c  = IO_SEL_NONE;
    tx_push_c = 1'b0;
    cnt_rst_c = 1'b0;
    if (st_we) begin
      io_sel_c = io_decode(st_addr[31:30], st_addr[4:2]);
    end
    tx_push_c = (io_sel_c == IO_SEL_UART_TX) & st_be[0];
    cnt_rst_c = (io_sel_c == IO_SEL_CNT_RST) & (|st_be);
  end

  assign tx_pop_c = ~fifo_empty & uart_tx_ready;

  io_tx_fifo #(
    .WIDTH (8),
    .DEPTH (TX_FIFO_DEPTH)
  ) u_tx_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (tx_push_c),
    .push_data (st_data[7:0]),
    .pop       (tx_pop_c),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count),
    .head_data (fifo_head)
  );

  // Sticky overflow on a push into a full FIFO that no pop makes room for
  always_comb begin
    overflow_d = overflow_q;
    if (tx_push_c & fifo_full & ~tx_pop_c) begin
      overflow_d = 1'b1;
    end
  end

  // Free-running cycle counter and retire counter; software reset overrides increments
  always_comb begin
    cyc_d   = cyc_q + CNT_WIDTH'(1);
    instr_d = instr_q;
    if (instr_retire) begin
      instr_d = instr_q + CNT_WIDTH'(1);
    end
    if (cnt_rst_c) begin
      cyc_d   = '0;
      instr_d = '0;
    end
  end

  // Controller state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_q <= 1'b0;
      cyc_q      <= '0;
      instr_q    <= '0;
    end else begin
      overflow_q <= overflow_d;
      cyc_q      <= cyc_d;
      instr_q    <= instr_d;
    end
  end

  assign uart_tx_valid   = ~fifo_empty;
  assign uart_tx_data    = fifo_head;
  assign tx_ready_status = (fifo_count != FIFO_CNT_W'(TX_FIFO_DEPTH));
  assign tx_overflow     = overflow_q;
  assign cyc_counter     = cyc_q;
  assign instr_counter   = instr_q;

endmodule

// File: tb/tb_mmio_store_ctrl.sv
// Directed self-checking bench for mmio_store_ctrl.
module tb_mmio_store_ctrl;

  localparam logic [31:0] A_TX   = 32'h8000_0008;
  localparam logic [31:0] A_CYC  = 32'h8000_0010;
  localparam logic [31:0] A_CRST = 32'h8000_0018;
  localparam logic [31:0] A_LOW  = 32'h0000_0008;

  logic        clk = 1'b0;
  logic        rst;
  logic        st_we;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic [3:0]  st_be;
  logic        instr_retire;
  logic        uart_tx_ready;
  logic [7:0]  uart_tx_data;
  logic        uart_tx_valid;
  logic        tx_ready_status;
  logic        tx_overflow;
  logic [31:0] cyc_counter;
  logic [31:0] instr_counter;

  logic [7:0]  n_tx_data;
  logic        n_tx_valid;
  logic        n_ready_status;
  logic        n_overflow;
  logic [3:0]  n_cyc;
  logic [3:0]  n_instr;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  mmio_store_ctrl dut (
    .clk             (clk),
    .rst             (rst),
    .st_we           (st_we),
    .st_addr         (st_addr),
    .st_data         (st_data),
    .st_be           (st_be),
    .instr_retire    (instr_retire),
    .uart_tx_data    (uart_tx_data),
    .uart_tx_valid   (uart_tx_valid),
    .uart_tx_ready   (uart_tx_ready),
    .tx_ready_status (tx_ready_status),
    .tx_overflow     (tx_overflow),
    .cyc_counter     (cyc_counter),
    .instr_counter   (instr_counter)
  );

  // Narrow-counter instance to observe wrap-around in a few cycles
  mmio_store_ctrl #(.TX_FIFO_DEPTH(4), .CNT_WIDTH(4)) u_narrow (
    .clk             (clk),
    .rst             (rst),
    .st_we           (st_we),
    .st_addr         (st_addr),
    .st_data         (st_data),
    .st_be           (st_be),
    .instr_retire    (instr_retire),
    .uart_tx_data    (n_tx_data),
    .uart_tx_valid   (n_tx_valid),
    .uart_tx_ready   (uart_tx_ready),
    .tx_ready_status (n_ready_status),
    .tx_overflow     (n_overflow),
    .cyc_counter     (n_cyc),
    .instr_counter   (n_instr)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be);
    st_we   = 1'b1;
    st_addr = addr;
    st_data = data;
    st_be   = be;
    tick();
    st_we   = 1'b0;
  endtask

  task automatic do_reset();
    rst           = 1'b1;
    st_we         = 1'b0;
    instr_retire  = 1'b0;
    uart_tx_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    rst = 1'b1;
    tick();
    checks++;
    if (uart_tx_valid !== 1'b0 || tx_ready_status !== 1'b1 || tx_overflow !== 1'b0) begin
      $display("FAIL reset_flags: valid=%b status=%b ovf=%b expected 0 1 0",
               uart_tx_valid, tx_ready_status, tx_overflow);
    end else passed++;
    checks++;
    if (cyc_counter !== 32'd0 || instr_counter !== 32'd0) begin
      $display("FAIL reset_counters: cyc=%0d instr=%0d expected 0 0", cyc_counter, instr_counter);
    end else passed++;
    rst = 1'b0;
    tick();
    checks++;
    if (cyc_counter !== 32'd1) begin
      $display("FAIL reset_first_count: cyc=%0d expected 1", cyc_counter);
    end else passed++;
  endtask

  task automatic test_single_tx();
    do_reset();
    uart_tx_ready = 1'b1;
    store(A_TX, 32'h0000_0041, 4'b0001);
    checks++;
    if (uart_tx_valid !== 1'b1 || uart_tx_data !== 8'h41) begin
      $display("FAIL single_tx_out: valid=%b data=%h expected 1 41", uart_tx_valid, uart_tx_data);
    end else passed++;
    tick();
    checks++;
    if (uart_tx_valid !== 1'b0) begin
      $display("FAIL single_tx_drained: valid=%b expected 0", uart_tx_valid);
    end else passed++;
    uart_tx_ready = 1'b0;
  endtask

  task automatic test_ignored_writes();
    do_reset();
    store(A_CYC, 32'h0000_0055, 4'b1111);
    store(A_TX, 32'h0000_5566, 4'b0010);
    store(A_LOW, 32'h0000_0077, 4'b0001);
    store(A_CRST, 32'h0000_0000, 4'b0000);
    st_addr = A_TX;
    st_data = 32'h0000_0088;
    st_be   = 4'b0001;
    tick();
    checks++;
    if (uart_tx_valid !== 1'b0 || tx_ready_status !== 1'b1) begin
      $display("FAIL ignored_no_push: valid=%b status=%b expected 0 1", uart_tx_valid, tx_ready_status);
    end else passed++;
    checks++;
    if (cyc_counter !== 32'd5) begin
      $display("FAIL ignored_no_cnt_rst: cyc=%0d expected 5", cyc_counter);
    end else passed++;
  endtask

  task automatic test_fill_overflow();
    do_reset();
    for (int i = 1; i <= 3; i++) store(A_TX, 32'(i), 4'b0001);
    checks++;
    if (tx_ready_status !== 1'b1) begin
      $display("FAIL fill_three_status: status=%b expected 1", tx_ready_status);
    end else passed++;
    store(A_TX, 32'h0000_0004, 4'b0001);
    checks++;
    if (tx_ready_status !== 1'b0 || tx_overflow !== 1'b0) begin
      $display("FAIL fill_full: status=%b ovf=%b expected 0 0", tx_ready_status, tx_overflow);
    end else passed++;
    store(A_TX, 32'h0000_0005, 4'b0001);
    checks++;
    if (tx_overflow !== 1'b1 || uart_tx_data !== 8'h01) begin
      $display("FAIL overflow_set: ovf=%b head=%h expected 1 01", tx_overflow, uart_tx_data);
    end else passed++;
    uart_tx_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      checks++;
      if (uart_tx_valid !== 1'b1 || uart_tx_data !== 8'(i)) begin
        $display("FAIL drain_order_%0d: valid=%b data=%h expected 1 %h", i, uart_tx_valid, uart_tx_data, 8'(i));
      end else passed++;
      tick();
    end
    checks++;
    if (uart_tx_valid !== 1'b0 || tx_overflow !== 1'b1) begin
      $display("FAIL drain_end: valid=%b ovf=%b expected 0 1", uart_tx_valid, tx_overflow);
    end else passed++;
    uart_tx_ready = 1'b0;
  endtask

  task automatic test_push_pop_full();
    do_reset();
    for (int i = 0; i < 4; i++) store(A_TX, 32'(8'hA0 + i), 4'b0001);
    uart_tx_ready = 1'b1;
    store(A_TX, 32'h0000_00A4, 4'b0001);
    checks++;
    if (tx_ready_status !== 1'b0 || tx_overflow !== 1'b0) begin
      $display("FAIL full_push_pop: status=%b ovf=%b expected 0 0", tx_ready_status, tx_overflow);
    end else passed++;
    for (int i = 1; i <= 4; i++) begin
      checks++;
      if (uart_tx_valid !== 1'b1 || uart_tx_data !== 8'(8'hA0 + i)) begin
        $display("FAIL full_push_pop_drain_%0d: valid=%b data=%h expected 1 %h",
                 i, uart_tx_valid, uart_tx_data, 8'(8'hA0 + i));
      end else passed++;
      tick();
    end
    checks++;
    if (uart_tx_valid !== 1'b0) begin
      $display("FAIL full_push_pop_empty: valid=%b expected 0", uart_tx_valid);
    end else passed++;
    uart_tx_ready = 1'b0;
  endtask

  task automatic test_counters();
    do_reset();
    for (int i = 0; i < 100; i++) begin
      instr_retire = (i % 2 == 0);
      tick();
    end
    instr_retire = 1'b0;
    checks++;
    if (cyc_counter !== 32'd100 || instr_counter !== 32'd50) begin
      $display("FAIL count_run: cyc=%0d instr=%0d expected 100 50", cyc_counter, instr_counter);
    end else passed++;
    instr_retire = 1'b1;
    uart_tx_ready = 1'b1;
    st_we = 1'b1; st_addr = A_TX; st_data = 32'h0000_0033; st_be = 4'b0001;
    tick();
    store(A_CRST, 32'h0, 4'b0100);
    checks++;
    if (cyc_counter !== 32'd0 || instr_counter !== 32'd0) begin
      $display("FAIL cnt_rst: cyc=%0d instr=%0d expected 0 0", cyc_counter, instr_counter);
    end else passed++;
    instr_retire = 1'b0;
    tick();
    checks++;
    if (cyc_counter !== 32'd1 || instr_counter !== 32'd0) begin
      $display("FAIL cnt_resume1: cyc=%0d instr=%0d expected 1 0", cyc_counter, instr_counter);
    end else passed++;
    instr_retire = 1'b1;
    tick();
    instr_retire = 1'b0;
    checks++;
    if (cyc_counter !== 32'd2 || instr_counter !== 32'd1) begin
      $display("FAIL cnt_resume2: cyc=%0d instr=%0d expected 2 1", cyc_counter, instr_counter);
    end else passed++;
    uart_tx_ready = 1'b0;
  endtask

  task automatic test_counter_wrap();
    do_reset();
    for (int i = 0; i < 15; i++) tick();
    checks++;
    if (n_cyc !== 4'hF) begin
      $display("FAIL wrap_max: cyc=%h expected f", n_cyc);
    end else passed++;
    tick();
    checks++;
    if (n_cyc !== 4'h0) begin
      $display("FAIL wrap_zero: cyc=%h expected 0", n_cyc);
    end else passed++;
  endtask

  task automatic test_rst_mid_drain();
    logic seen;
    do_reset();
    for (int i = 1; i <= 3; i++) store(A_TX, 32'(8'hB0 + i), 4'b0001);
    checks++;
    if (uart_tx_valid !== 1'b1 || uart_tx_data !== 8'hB1) begin
      $display("FAIL pre_rst_buffered: valid=%b data=%h expected 1 b1", uart_tx_valid, uart_tx_data);
    end else passed++;
    rst = 1'b1;
    st_we = 1'b1; st_addr = A_TX; st_data = 32'h0000_00EE; st_be = 4'b0001;
    tick();
    st_we = 1'b0;
    checks++;
    if (uart_tx_valid !== 1'b0 || tx_ready_status !== 1'b1) begin
      $display("FAIL rst_mid_drain: valid=%b status=%b expected 0 1", uart_tx_valid, tx_ready_status);
    end else passed++;
    rst = 1'b0;
    uart_tx_ready = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (uart_tx_valid !== 1'b0) seen = 1'b1;
      tick();
    end
    checks++;
    if (seen !== 1'b0) begin
      $display("FAIL rst_bytes_dropped: stale valid seen=%b expected 0", seen);
    end else passed++;
    uart_tx_ready = 1'b0;
  endtask

  initial begin
    rst           = 1'b1;
    st_we         = 1'b0;
    st_addr       = '0;
    st_data       = '0;
    st_be         = '0;
    instr_retire  = 1'b0;
    uart_tx_ready = 1'b0;
    test_reset();
    test_single_tx();
    test_ignored_writes();
    test_fill_overflow();
    test_push_pop_full();
    test_counters();
    test_counter_wrap();
    test_rst_mid_drain();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
